// File: rtl/softmax_max_sched.sv
// Streams a signed vector through an external registered compare-exchange unit and returns its maximum.
// Define SOFTMAX_MAX_ARGMAX_EN to add argmax_out (index of the first maximum).
module softmax_max_sched #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] cx_a,
  output logic [DATA_WIDTH-1:0] cx_b,
  input  logic [DATA_WIDTH-1:0] cx_major,
  input  logic [DATA_WIDTH-1:0] cx_minor,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] max_out,
  output logic                  max_valid
`ifdef SOFTMAX_MAX_ARGMAX_EN
  ,
  output logic [LEN_WIDTH-1:0]  argmax_out
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 accept;
  logic                 start_ok;

  // The min result of the unit is never needed.
  logic unused_minor;
  assign unused_minor = ^cx_minor;

  assign accept   = in_valid && in_ready;
  assign start_ok = (state_q == S_IDLE) && start;
  assign cnt_inc  = cnt_q + LEN_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and compare-exchange operand steering.
  always_comb begin
    state_d = state_q;
    cx_a    = MIN_VAL;
    cx_b    = MIN_VAL;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (vec_len == '0) ? S_DRAIN : S_ACCUM;
      end
      S_ACCUM: begin
        cx_b = cx_major;
        cx_a = accept ? in_data : cx_major;
        if (accept && (cnt_inc == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cx_a    = cx_major;
        cx_b    = cx_major;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      len_q     <= '0;
      max_out   <= '0;
      max_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == S_ACCUM);
      busy      <= (state_d != S_IDLE);
      max_valid <= (state_q == S_DRAIN);
      if (start_ok) begin
        len_q <= vec_len;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_inc;
      end
      if (state_q == S_DRAIN) max_out <= cx_major;
    end
  end

`ifdef SOFTMAX_MAX_ARGMAX_EN
  logic [LEN_WIDTH-1:0]  pend_idx;
  logic [DATA_WIDTH-1:0] pend_prev;
  logic                  pend_vld;
  logic [LEN_WIDTH-1:0]  idx_reg;
  logic [LEN_WIDTH-1:0]  idx_upd;

  // The unit returns the old max on ties, so a changed max means a strict win.
  assign idx_upd = (pend_vld && (cx_major != pend_prev)) ? pend_idx : idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_idx   <= '0;
      pend_prev  <= '0;
      pend_vld   <= 1'b0;
      idx_reg    <= '0;
      argmax_out <= '0;
    end else begin
      pend_vld <= accept;
      if (accept) begin
        pend_idx  <= cnt_q;
        pend_prev <= cx_b;
      end
      if (start_ok) idx_reg <= '0;
      else          idx_reg <= idx_upd;
      if (state_q == S_DRAIN) argmax_out <= idx_upd;
    end
  end
`endif

endmodule

// File: tb/tb_softmax_max_sched.sv
// Scoreboard bench for softmax_max_sched with a behavioural compare-exchange unit.
// Expected results are queued at start; a negedge monitor checks each max_valid pulse.
module tb_softmax_max_sched;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] vec_len;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] cx_a;
  logic [DW-1:0] cx_b;
  logic [DW-1:0] cx_major;
  logic [DW-1:0] cx_minor;
  logic          busy;
  logic [DW-1:0] max_out;
  logic          max_valid;
`ifdef SOFTMAX_MAX_ARGMAX_EN
  logic [LW-1:0] argmax_out;
`endif

  softmax_max_sched #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cx_a(cx_a), .cx_b(cx_b), .cx_major(cx_major), .cx_minor(cx_minor),
    .busy(busy), .max_out(max_out), .max_valid(max_valid)
`ifdef SOFTMAX_MAX_ARGMAX_EN
    , .argmax_out(argmax_out)
`endif
  );

  always #5 clk = ~clk;

  // Registered compare-exchange unit; ties return b.
  always @(posedge clk) begin
    if ($signed(cx_a) > $signed(cx_b)) begin
      cx_major <= cx_a;
      cx_minor <= cx_b;
    end else begin
      cx_major <= cx_b;
      cx_minor <= cx_a;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int mx;
    int ix;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   vd[256];
  int   vb[256];
  int   busy_start_at = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every max_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && max_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_max_valid: got max_out=%0d at cycle %0d expected no pulse",
                 $signed(max_out), cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("max_out", longint'($signed(max_out)), longint'(mon_e.mx));
`ifdef SOFTMAX_MAX_ARGMAX_EN
        chk("argmax_out", longint'(argmax_out), longint'(mon_e.ix));
`endif
        chk("max_valid_cycle", longint'(cyc), longint'(mon_e.cyc));
      end
    end
  end

  task automatic clear_stim();
    for (int i = 0; i < 256; i++) begin
      vd[i] = 0;
      vb[i] = 0;
    end
    busy_start_at = -1;
  endtask

  task automatic run_vec(input int len, input int exp_mx, input int exp_ix, input int lat);
    int s;
    @(posedge clk); #1;
    start   = 1'b1;
    vec_len = LW'(len);
    s       = cyc;
    exp_q.push_back('{mx: exp_mx, ix: exp_ix, cyc: s + lat});
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", longint'(busy), 1);
    chk("in_ready_after_start", longint'(in_ready), (len != 0) ? 1 : 0);
    for (int i = 0; i < len; i++) begin
      repeat (vb[i]) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == busy_start_at) begin
        start   = 1'b1;
        vec_len = LW'(2);
      end
      in_valid = 1'b1;
      in_data  = DW'(vd[i]);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (len != 0) chk("in_ready_drop", longint'(in_ready), 0);
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_max_valid: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_in_ready"}, longint'(in_ready), 0);
    chk({tag, "_max_out"}, longint'(max_out), 0);
    chk({tag, "_max_valid"}, longint'(max_valid), 0);
`ifdef SOFTMAX_MAX_ARGMAX_EN
    chk({tag, "_argmax_out"}, longint'(argmax_out), 0);
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    vec_len  = '0;
    in_data  = '0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    rst_n = 1'b1;

    // Simple vector
    clear_stim();
    vd[0] = 3; vd[1] = -5; vd[2] = 7; vd[3] = 7; vd[4] = 2;
    run_vec(5, 7, 2, 7);

    // All MIN, then MIN with a late winner
    clear_stim();
    vd[0] = -128; vd[1] = -128; vd[2] = -128;
    run_vec(3, -128, 0, 5);
    clear_stim();
    vd[0] = -128; vd[1] = -128; vd[2] = -127;
    run_vec(3, -127, 2, 5);

    // Empty vector
    clear_stim();
    run_vec(0, -128, 0, 2);

    // Two bubbles after the second element
    clear_stim();
    vd[0] = 1; vd[1] = 9; vd[2] = 4; vd[3] = 9;
    vb[2] = 2;
    run_vec(4, 9, 1, 8);

    // Set max_out non-zero, then reset mid-vector
    clear_stim();
    vd[0] = 3; vd[1] = -5; vd[2] = 7; vd[3] = 7; vd[4] = 2;
    run_vec(5, 7, 2, 7);
    @(posedge clk); #1;
    start   = 1'b1;
    vec_len = LW'(5);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(10);
    @(posedge clk); #1;
    in_data  = DW'(20);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_reset_state("mid_reset");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    clear_stim();
    vd[0] = 5; vd[1] = 6;
    run_vec(2, 6, 1, 4);

    // start pulsed during ACCUM must be ignored
    clear_stim();
    vd[0] = 3; vd[1] = -5; vd[2] = 7; vd[3] = 7; vd[4] = 2;
    busy_start_at = 2;
    run_vec(5, 7, 2, 7);

    // Max-length ascending ramp
    clear_stim();
    for (int i = 0; i < 255; i++) vd[i] = -127 + i;
    run_vec(255, 127, 254, 257);

    repeat (4) @(posedge clk);
    #1;
    chk("no_stray_results", longint'(exp_q.size()), 0);
    chk("idle_at_end", longint'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
